// File: rtl/ej32_mem_io_if.sv
// Load/store byte bus plus host RX/TX byte streams for the eJ32 memory responder.
// master = initiator side (CPU load/store unit and host), slave = ej32_mem_io.
interface ej32_mem_io_if #(
    parameter int ASZ = 17,
    parameter int PW  = 10
);
    logic [ASZ-1:0] cpu_addr;
    logic [7:0]     cpu_wdata;
    logic           cpu_we;
    logic [7:0]     cpu_rdata;
    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           rx_ready;
    logic [PW-1:0]  rx_ptr;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic           tx_ovf;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, rx_valid, rx_data, tx_ready,
        input  cpu_rdata, rx_ready, rx_ptr, tx_valid, tx_data, tx_ovf
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, rx_valid, rx_data, tx_ready,
        output cpu_rdata, rx_ready, rx_ptr, tx_valid, tx_data, tx_ovf
    );
endinterface

// File: rtl/ej32_mem_io.sv
// Byte RAM responder with TIB receive bridge and OBUF transmit FIFO; reads return one cycle later.
// RX stalls while the CPU writes; TX holds in the FIFO until tx_ready, overflowing OBUF writes are dropped and flagged.
module ej32_mem_io #(
    parameter int ASZ    = 17,
    parameter int TIB    = 'h1000,
    parameter int TIBSZ  = 'h400,
    parameter int OBUF   = 'h1400,
    parameter int OBUFSZ = 'h400,
    parameter int TXLG   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ej32_mem_io_if.slave bus
);
    localparam int PW    = $clog2(TIBSZ);
    localparam int DEPTH = 2 ** TXLG;
    localparam logic [ASZ-1:0] TIB_A   = ASZ'(TIB);
    localparam logic [ASZ:0]   OBUF_LO = (ASZ+1)'(OBUF);
    localparam logic [ASZ:0]   OBUF_HI = (ASZ+1)'(OBUF + OBUFSZ);
    localparam logic [TXLG:0]  FULL_N  = (TXLG+1)'(DEPTH);

    logic [7:0]      mem [2**ASZ];
    logic [7:0]      fifo_q [DEPTH];
    logic [7:0]      rdata_q;
    logic [PW-1:0]   rx_ptr_q, rx_ptr_d;
    logic [TXLG-1:0] wr_ptr_q, wr_ptr_d;
    logic [TXLG-1:0] rd_ptr_q, rd_ptr_d;
    logic [TXLG:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            rx_fire, push_req, push, pop, full, empty;
    logic [ASZ:0]    addr_ext;

    always_comb begin
        addr_ext = {1'b0, bus.cpu_addr};
        rx_fire  = bus.rx_valid && !bus.cpu_we;
        empty    = (cnt_q == '0);
        full     = (cnt_q == FULL_N);
        push_req = bus.cpu_we && (addr_ext >= OBUF_LO) && (addr_ext < OBUF_HI);
        pop      = !empty && bus.tx_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
        push     = push_req && (!full || pop);
        ovf_d    = ovf_q || (push_req && !push);

        rx_ptr_d = rx_ptr_q;
        if (rx_fire) begin
            rx_ptr_d = rx_ptr_q + PW'(1);
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + TXLG'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + TXLG'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (TXLG+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (TXLG+1)'(1);
        end
    end

    // Single RAM write port: the CPU has priority, RX only lands when the CPU is idle.
    always_ff @(posedge clk) begin
        if (bus.cpu_we) begin
            mem[bus.cpu_addr] <= bus.cpu_wdata;
        end else if (rx_fire) begin
            mem[TIB_A + ASZ'(rx_ptr_q)] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rx_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rdata_q  <= mem[bus.cpu_addr];
            rx_ptr_q <= rx_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.rx_ready  = !bus.cpu_we;
    assign bus.rx_ptr    = rx_ptr_q;
    assign bus.tx_valid  = !empty;
    assign bus.tx_data   = empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign bus.tx_ovf    = ovf_q;
endmodule

// File: tb/tb_ej32_mem_io.sv
// Directed vector table, hand-written FIFO/RX/reset sequences and a randomized run against a queue-based model.
module tb_ej32_mem_io;
    localparam int ASZ     = 17;
    localparam int TIB     = 'h1000;
    localparam int TIBSZ   = 'h400;
    localparam int OBUF    = 'h1400;
    localparam int OBUFSZ  = 'h400;
    localparam int TXDEPTH = 16;

    logic clk;
    logic rst_n;

    ej32_mem_io_if #(.ASZ(ASZ), .PW(10)) bus ();

    ej32_mem_io #(
        .ASZ(ASZ), .TIB(TIB), .TIBSZ(TIBSZ), .OBUF(OBUF), .OBUFSZ(OBUFSZ), .TXLG(4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: sparse byte memory, TX queue, RX pointer, sticky overflow.
    logic [7:0] m_mem [int];
    logic [7:0] txq [$];
    int         m_rxp;
    bit         m_ovf;
    bit         rd_known;
    logic [7:0] exp_rd;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wd;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic        chk_rd;
        logic [7:0]  rd;
        logic        rdy;
        logic [9:0]  ptr;
        logic        tv;
        logic [7:0]  td;
        logic        ovf;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input int addr, input logic [7:0] wd,
                         input logic rxv, input logic [7:0] rxd, input logic txr);
        bus.cpu_we    = we;
        bus.cpu_addr  = ASZ'(addr);
        bus.cpu_wdata = wd;
        bus.rx_valid  = rxv;
        bus.rx_data   = rxd;
        bus.tx_ready  = txr;
    endtask

    task automatic model_reset();
        txq.delete();
        m_rxp    = 0;
        m_ovf    = 1'b0;
        rd_known = 1'b1;
        exp_rd   = 8'h00;
    endtask

    // Advance one clock: update the model from the inputs currently applied, then sample #1 after the edge.
    task automatic tick();
        int a;
        bit pop, full, preq;
        a        = int'(bus.cpu_addr);
        rd_known = m_mem.exists(a);
        if (rd_known) exp_rd = m_mem[a];
        pop  = (txq.size() > 0) && bus.tx_ready;
        full = (txq.size() == TXDEPTH);
        preq = bus.cpu_we && (a >= OBUF) && (a < OBUF + OBUFSZ);
        if (pop) void'(txq.pop_front());
        if (preq) begin
            if (full && !pop) m_ovf = 1'b1;
            else txq.push_back(bus.cpu_wdata);
        end
        if (bus.cpu_we) begin
            m_mem[a] = bus.cpu_wdata;
        end else if (bus.rx_valid) begin
            m_mem[TIB + m_rxp] = bus.rx_data;
            m_rxp = (m_rxp + 1) % TIBSZ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        if (rd_known) chk("rnd_rdata", 32'(bus.cpu_rdata), 32'(exp_rd));
        chk("rnd_tx_valid", 32'(bus.tx_valid), 32'(txq.size() > 0));
        chk("rnd_tx_data", 32'(bus.tx_data), (txq.size() > 0) ? 32'(txq[0]) : 32'h0);
        chk("rnd_tx_ovf", 32'(bus.tx_ovf), 32'(m_ovf));
        chk("rnd_rx_ptr", 32'(bus.rx_ptr), 32'(m_rxp));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 32'h0);
        chk({tag, "_rx_ptr"}, 32'(bus.rx_ptr), 32'h0);
        chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'h0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'h0);
        chk({tag, "_tx_ovf"}, 32'(bus.tx_ovf), 32'h0);
    endtask

    initial begin
        int a;
        tbl[0]  = '{1'b1, 17'h00040, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 17'h00040, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 10'd0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 17'h00040, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 10'd0, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 17'h00040, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b1, 10'd0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 17'h00040, 8'h3C, 1'b1, 8'h31, 1'b1, 1'b1, 8'h3C, 1'b0, 10'd0, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 17'h01000, 8'h00, 1'b1, 8'h31, 1'b1, 1'b0, 8'h00, 1'b1, 10'd1, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 17'h01000, 8'h00, 1'b1, 8'h32, 1'b1, 1'b1, 8'h31, 1'b1, 10'd2, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 17'h01001, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h32, 1'b1, 10'd2, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 17'h01400, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 10'd2, 1'b1, 8'h48, 1'b0};
        tbl[9]  = '{1'b1, 17'h01401, 8'h49, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 10'd2, 1'b1, 8'h49, 1'b0};
        tbl[10] = '{1'b0, 17'h01400, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h48, 1'b1, 10'd2, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 17'h01401, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h49, 1'b1, 10'd2, 1'b0, 8'h00, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 0, 8'h00, 1'b0, 8'h00, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero("reset");

        // Directed vectors: read/write, read-before-write, RX stall, in-order TX.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].we, int'(tbl[i].addr), tbl[i].wd, tbl[i].rxv, tbl[i].rxd, tbl[i].txr);
            #1;
            chk($sformatf("vec%0d_rx_ready", i), 32'(bus.rx_ready), 32'(tbl[i].rdy));
            tick();
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(tbl[i].rd));
            chk($sformatf("vec%0d_rx_ptr", i), 32'(bus.rx_ptr), 32'(tbl[i].ptr));
            chk($sformatf("vec%0d_tx_valid", i), 32'(bus.tx_valid), 32'(tbl[i].tv));
            chk($sformatf("vec%0d_tx_data", i), 32'(bus.tx_data), 32'(tbl[i].td));
            chk($sformatf("vec%0d_tx_ovf", i), 32'(bus.tx_ovf), 32'(tbl[i].ovf));
        end

        // RX pointer wraps silently: 1022 more bytes from offset 2 land back at 0.
        for (int i = 0; i < TIBSZ - 2; i++) begin
            drive(1'b0, 'h40, 8'h00, 1'b1, 8'(i), 1'b1);
            tick();
        end
        chk("rx_wrap_ptr", 32'(bus.rx_ptr), 32'h0);
        drive(1'b0, 'h13FF, 8'h00, 1'b1, 8'h77, 1'b1);
        tick();
        chk("rx_after_wrap_ptr", 32'(bus.rx_ptr), 32'h1);
        chk("rx_last_byte", 32'(bus.cpu_rdata), 32'(8'hFD));

        // Fill the TX FIFO with no consumer.
        for (int i = 0; i < TXDEPTH; i++) begin
            drive(1'b1, OBUF + i, 8'(8'h10 + i), 1'b0, 8'h00, 1'b0);
            tick();
            if (i == 0) chk("fill_first_tx_valid", 32'(bus.tx_valid), 32'h1);
        end
        chk("fill16_tx_ovf", 32'(bus.tx_ovf), 32'h0);
        chk("fill16_tx_data", 32'(bus.tx_data), 32'h10);
        // Full with simultaneous pop: both happen, no overflow.
        drive(1'b1, OBUF + 16, 8'h20, 1'b0, 8'h00, 1'b1);
        tick();
        chk("fullpp_tx_ovf", 32'(bus.tx_ovf), 32'h0);
        chk("fullpp_tx_data", 32'(bus.tx_data), 32'h11);
        // Full without pop: dropped, sticky overflow.
        drive(1'b1, OBUF + 17, 8'h21, 1'b0, 8'h00, 1'b0);
        tick();
        chk("drop_tx_ovf", 32'(bus.tx_ovf), 32'h1);
        drive(1'b0, 'h40, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < TXDEPTH; i++) begin
            chk($sformatf("drain%0d_tx_valid", i), 32'(bus.tx_valid), 32'h1);
            chk($sformatf("drain%0d_tx_data", i), 32'(bus.tx_data), (i < 15) ? 32'(8'h11 + i) : 32'h20);
            tick();
        end
        chk("drained_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("drained_tx_ovf", 32'(bus.tx_ovf), 32'h1);

        // Asynchronous reset in the middle of activity.
        drive(1'b1, OBUF, 8'h55, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 'h40, 8'h00, 1'b1, 8'h66, 1'b0);
        tick();
        tick();
        chk("pre_rst_tx_valid", 32'(bus.tx_valid), 32'h1);
        chk("pre_rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h3C);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 'h40, 8'h00, 1'b0, 8'h00, 1'b0);
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_zero("post_rst");

        // Randomized traffic around the TIB/OBUF windows and their edges.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0: a = 'h40 + int'($urandom_range(0, 15));
                1: a = TIB + int'($urandom_range(0, 15));
                2: a = OBUF + int'($urandom_range(0, 15));
                3: a = OBUF + OBUFSZ - 2 + int'($urandom_range(0, 3));
                default: a = OBUF - 2 + int'($urandom_range(0, 3));
            endcase
            drive(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 2) == 0));
            #1;
            chk("rnd_rx_ready", 32'(bus.rx_ready), 32'(!bus.cpu_we));
            tick();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
